imem_port_arbiter: RTL and testbench

- Shares one single-port instruction memory macro between two requesters.
  - Fetch: read-only, high priority.
  - Loader/debug: read/write, low priority with starvation guard.
- Sits between the fetch stage / program loader and the synchronous-read memory macro.
- The macro has 1-cycle read latency; the word index is the byte address shifted right by 2; douta is 0 on idle cycles and holds its old value on write cycles.
- The block issues at most one access per cycle and routes each result back to its owner.

---
 rtl/imem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_imem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// Arbiter sharing one single-port, 1-cycle-latency instruction memory macro
// between a high-priority fetch reader and a low-priority loader/debug port.
// The loader is protected from starvation by a saturating wait counter.
//
// Handshake: a request transfers on a cycle where valid & ready are both 1;
// the requester holds address/data stable until then. Responses carry no
// back-pressure and appear exactly one cycle after the transfer.
module imem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  f_req_valid,
    input  logic [ADDR_WIDTH-1:0] f_req_addr,
    output logic                  f_req_ready,
    input  logic                  f_flush,
    output logic                  f_rsp_valid,
    output logic [DATA_WIDTH-1:0] f_rsp_data,
    input  logic                  l_req_valid,
    input  logic                  l_req_we,
    input  logic [ADDR_WIDTH-1:0] l_req_addr,
    input  logic [DATA_WIDTH-1:0] l_req_wdata,
    output logic                  l_req_ready,
    output logic                  l_rsp_valid,
    output logic [DATA_WIDTH-1:0] l_rsp_data,
    output logic                  mem_ena,
    output logic                  mem_wea,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    // Tag of the access issued last cycle; selects who owns mem_dout now.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_F_RD = 2'd1,
        TAG_L_RD = 2'd2,
        TAG_L_WR = 2'd3
    } tag_e;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    tag_e       tag_q, tag_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       fetch_ok;
    logic       grant_f, grant_l;

    assign fetch_ok = f_req_valid & ~f_flush;

    // Grant selection; nothing is granted while reset is held.
    always_comb begin
        grant_f = 1'b0;
        grant_l = 1'b0;
        if (!rsta) begin
            if ((wait_cnt_q == MAX_WAIT_C) && l_req_valid) begin
                grant_l = 1'b1;
            end else if (fetch_ok) begin
                grant_f = 1'b1;
            end else if (l_req_valid) begin
                grant_l = 1'b1;
            end
        end
    end

    assign f_req_ready = grant_f;
    assign l_req_ready = grant_l;

    // Drive the macro from whichever requester won; all zero when idle.
    always_comb begin
        mem_ena  = 1'b0;
        mem_wea  = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (grant_f) begin
            mem_ena  = 1'b1;
            mem_addr = f_req_addr;
            mem_din  = l_req_wdata;
        end else if (grant_l) begin
            mem_ena  = 1'b1;
            mem_wea  = l_req_we;
            mem_addr = l_req_addr;
            mem_din  = l_req_wdata;
        end
    end

    // Next tag and starvation counter from this cycle's grant.
    always_comb begin
        tag_d      = TAG_NONE;
        wait_cnt_d = wait_cnt_q;
        if (grant_f) begin
            tag_d = TAG_F_RD;
        end else if (grant_l) begin
            tag_d = l_req_we ? TAG_L_WR : TAG_L_RD;
        end
        if (grant_l) begin
            wait_cnt_d = 4'd0;
        end else if (l_req_valid && (wait_cnt_q < MAX_WAIT_C)) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    // State registers.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            tag_q      <= TAG_NONE;
            wait_cnt_q <= 4'd0;
        end else begin
            tag_q      <= tag_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Route the macro's output to the owner of last cycle's access.
    always_comb begin
        f_rsp_valid = 1'b0;
        f_rsp_data  = '0;
        l_rsp_valid = 1'b0;
        l_rsp_data  = '0;
        case (tag_q)
            TAG_F_RD: begin
                f_rsp_valid = ~f_flush;
                f_rsp_data  = mem_dout;
            end
            TAG_L_RD: begin
                l_rsp_valid = 1'b1;
                l_rsp_data  = mem_dout;
            end
            TAG_L_WR: begin
                l_rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: a behavioural memory macro, a reference model
// of the arbitration rules that pushes expected responses into queues, and a
// monitor that pops and compares whatever the DUT returns.
module tb_imem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;

  // clock / reset
  logic clka = 1'b0;
  logic rsta = 1'b1;
  always #5 clka = ~clka;

  logic          f_req_valid = 1'b0;
  logic [AW-1:0] f_req_addr = '0;
  logic          f_req_ready;
  logic          f_flush = 1'b0;
  logic          f_rsp_valid;
  logic [DW-1:0] f_rsp_data;
  logic          l_req_valid = 1'b0;
  logic          l_req_we = 1'b0;
  logic [AW-1:0] l_req_addr = '0;
  logic [DW-1:0] l_req_wdata = '0;
  logic          l_req_ready;
  logic          l_rsp_valid;
  logic [DW-1:0] l_rsp_data;
  logic          mem_ena;
  logic          mem_wea;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout = '0;

  imem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clka(clka), .rsta(rsta),
    .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(f_req_ready),
    .f_flush(f_flush), .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data),
    .l_req_valid(l_req_valid), .l_req_we(l_req_we), .l_req_addr(l_req_addr),
    .l_req_wdata(l_req_wdata), .l_req_ready(l_req_ready),
    .l_rsp_valid(l_rsp_valid), .l_rsp_data(l_rsp_data),
    .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // behavioural memory macro (64 words)
  logic [DW-1:0] mem_arr [64];
  always @(posedge clka) begin
    if (mem_ena) begin
      if (mem_wea) mem_arr[mem_addr[7:2]] <= mem_din;
      else         mem_dout <= mem_arr[mem_addr[7:2]];
    end else begin
      mem_dout <= '0;
    end
  end

  // scoreboard state
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [DW-1:0] ref_mem [64];
  logic [DW-1:0] f_exp_q[$];
  int            f_cyc_q[$];
  logic [DW-1:0] l_exp_q[$];
  int            l_cyc_q[$];
  int  w_model = 0;
  logic f_acc = 1'b0;
  logic l_acc = 1'b0;
  logic rec_en = 1'b0;
  logic [1:0] hist_q[$];

  always @(posedge clka) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=0x%08h want=0x%08h", nm, cyc, act, exp);
    end
  endtask

  // reference model: predicts grants, memory drive and pushes expected responses
  always @(negedge clka) begin : model
    logic fok, gl, gf;
    if (rsta) begin
      w_model = 0;
      f_acc = 1'b0;
      l_acc = 1'b0;
      chk("rst_f_req_ready", {31'd0, f_req_ready}, 32'd0);
      chk("rst_l_req_ready", {31'd0, l_req_ready}, 32'd0);
      chk("rst_mem_ena", {31'd0, mem_ena}, 32'd0);
      chk("rst_mem_wea", {31'd0, mem_wea}, 32'd0);
    end else begin
      fok = f_req_valid && !f_flush;
      gl  = l_req_valid && ((w_model == MW) || !fok);
      gf  = fok && !gl;
      chk("f_req_ready", {31'd0, f_req_ready}, {31'd0, gf});
      chk("l_req_ready", {31'd0, l_req_ready}, {31'd0, gl});
      chk("mem_ena", {31'd0, mem_ena}, {31'd0, gf | gl});
      if (gf) begin
        chk("mem_wea_f", {31'd0, mem_wea}, 32'd0);
        chk("mem_addr_f", mem_addr, f_req_addr);
        f_exp_q.push_back(ref_mem[f_req_addr[7:2]]);
        f_cyc_q.push_back(cyc);
      end else if (gl) begin
        chk("mem_wea_l", {31'd0, mem_wea}, {31'd0, l_req_we});
        chk("mem_addr_l", mem_addr, l_req_addr);
        if (l_req_we) begin
          chk("mem_din_l", mem_din, l_req_wdata);
          ref_mem[l_req_addr[7:2]] = l_req_wdata;
          l_exp_q.push_back('0);
        end else begin
          l_exp_q.push_back(ref_mem[l_req_addr[7:2]]);
        end
        l_cyc_q.push_back(cyc);
      end else begin
        chk("idle_mem_addr", mem_addr, '0);
        chk("idle_mem_wea", {31'd0, mem_wea}, 32'd0);
        chk("idle_mem_din", mem_din, '0);
      end
      if (gl) w_model = 0;
      else if (l_req_valid && w_model < MW) w_model = w_model + 1;
      f_acc = gf;
      l_acc = gl;
      if (rec_en) hist_q.push_back({gf, gl});
    end
  end

  // monitor: pops expected responses and compares against DUT outputs
  always @(negedge clka) begin : monitor
    logic [DW-1:0] e;
    if (rsta) begin
      f_exp_q.delete(); f_cyc_q.delete();
      l_exp_q.delete(); l_cyc_q.delete();
      chk("rst_f_rsp_valid", {31'd0, f_rsp_valid}, 32'd0);
      chk("rst_l_rsp_valid", {31'd0, l_rsp_valid}, 32'd0);
      chk("rst_f_rsp_data", f_rsp_data, '0);
      chk("rst_l_rsp_data", l_rsp_data, '0);
    end else begin
      if (f_cyc_q.size() > 0 && f_cyc_q[0] == cyc - 1) begin
        e = f_exp_q.pop_front();
        void'(f_cyc_q.pop_front());
        if (f_flush) begin
          chk("f_rsp_valid_flushed", {31'd0, f_rsp_valid}, 32'd0);
        end else begin
          chk("f_rsp_valid", {31'd0, f_rsp_valid}, 32'd1);
          chk("f_rsp_data", f_rsp_data, e);
        end
      end else begin
        chk("f_rsp_valid_none", {31'd0, f_rsp_valid}, 32'd0);
        chk("f_rsp_data_none", f_rsp_data, '0);
      end
      if (l_cyc_q.size() > 0 && l_cyc_q[0] == cyc - 1) begin
        e = l_exp_q.pop_front();
        void'(l_cyc_q.pop_front());
        chk("l_rsp_valid", {31'd0, l_rsp_valid}, 32'd1);
        chk("l_rsp_data", l_rsp_data, e);
      end else begin
        chk("l_rsp_valid_none", {31'd0, l_rsp_valid}, 32'd0);
        chk("l_rsp_data_none", l_rsp_data, '0);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic drive_f(input logic v, input logic [AW-1:0] a);
    f_req_valid = v;
    f_req_addr  = a;
  endtask

  task automatic drive_l(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    l_req_valid = v;
    l_req_we    = we;
    l_req_addr  = a;
    l_req_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = $urandom;
      mem_arr[i] = ref_mem[i];
    end
    ref_mem[0] = 32'h11; mem_arr[0] = 32'h11;
    ref_mem[1] = 32'h22; mem_arr[1] = 32'h22;
    ref_mem[2] = 32'h33; mem_arr[2] = 32'h33;

    repeat (3) tick();
    rsta = 1'b0;

    // fetch-only stream
    drive_f(1'b1, 32'h00); tick();
    drive_f(1'b1, 32'h04); tick();
    drive_f(1'b1, 32'h08); tick();
    drive_f(1'b0, 32'h00); tick();

    // loader write then read back
    drive_l(1'b1, 1'b1, 32'h40, 32'hDEADBEEF); tick();
    drive_l(1'b1, 1'b0, 32'h40, 32'h0); tick();
    drive_l(1'b0, 1'b0, 32'h0, 32'h0); tick();

    // idle
    repeat (3) tick();

    // flush: fetch accepted, flush next cycle with a pending loader write
    drive_f(1'b1, 32'h10); tick();
    drive_f(1'b1, 32'h14); f_flush = 1'b1;
    drive_l(1'b1, 1'b1, 32'h80, 32'hCAFEF00D); tick();
    f_flush = 1'b0; drive_l(1'b0, 1'b0, 32'h0, 32'h0); tick();
    drive_f(1'b0, 32'h0); tick();

    // reset mid-flight after a loader read grant
    drive_l(1'b1, 1'b0, 32'h40, 32'h0); tick();
    rsta = 1'b1; drive_l(1'b0, 1'b0, 32'h0, 32'h0); tick();
    tick();
    rsta = 1'b0; tick();

    // contention: expect FFFFL repeating
    rec_en = 1'b1;
    drive_f(1'b1, 32'h20);
    drive_l(1'b1, 1'b0, 32'h44, 32'h0);
    repeat (15) tick();
    rec_en = 1'b0;
    drive_f(1'b0, 32'h0); drive_l(1'b0, 1'b0, 32'h0, 32'h0); tick();
    chk("contention_len", hist_q.size(), 15);
    for (int i = 0; i < 15 && i < hist_q.size(); i++)
      chk($sformatf("contention_%0d", i), {30'd0, hist_q[i]}, (i % 5 == 4) ? 32'd1 : 32'd2);

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      if (!f_req_valid || f_acc)
        drive_f($urandom_range(0, 3) != 0, {24'd0, 6'($urandom_range(0, 63)), 2'b00});
      if (!l_req_valid || l_acc)
        drive_l($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                {24'd0, 6'($urandom_range(0, 63)), 2'b00}, $urandom);
      f_flush = ($urandom_range(0, 9) == 0);
      tick();
    end
    drive_f(1'b0, 32'h0); drive_l(1'b0, 1'b0, 32'h0, 32'h0); f_flush = 1'b0;
    repeat (3) tick();
    chk("f_queue_drained", f_exp_q.size(), 0);
    chk("l_queue_drained", l_exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
